// File: rtl/muldiv_iter.sv
// Iterative RV-M multiply/divide unit: shift-add multiply, restoring divide,
// single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_iter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_UNROLL = 1,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_div_by_zero,
  output logic             out_overflow
);

  localparam int unsigned    MulIters = XLEN / MUL_UNROLL;
  localparam int unsigned    CntW     = $clog2(XLEN);
  localparam logic [CntW-1:0] MulLast = CntW'(MulIters - 1);
  localparam logic [CntW-1:0] DivLast = CntW'(XLEN - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFixup, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d, acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic              dz_q, dz_d, ovf_q, ovf_d;

  logic              accept, is_mul, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [2*XLEN-1:0] mul_sum, prod, div_next;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quo, rem, fix_result;

  assign in_ready        = (state_q == StIdle);
  assign out_valid       = (state_q == StDone);
  assign out_result      = result_q;
  assign out_tag         = tag_q;
  assign out_div_by_zero = dz_q;
  assign out_overflow    = ovf_q;

  // Request decode: signedness per operand, magnitudes and fast-path detection.
  always_comb begin
    accept   = in_valid && in_ready && !flush;
    is_mul   = !in_op[2];
    sgn_a    = is_mul ? (in_op[1:0] != 2'b11) : !in_op[0];
    sgn_b    = is_mul ? !in_op[1] : !in_op[0];
    neg_a    = sgn_a && in_a[XLEN-1];
    neg_b    = sgn_b && in_b[XLEN-1];
    a_mag    = neg_a ? -in_a : in_a;
    b_mag    = neg_b ? -in_b : in_b;
    div_zero = !is_mul && (in_b == '0);
    div_ovf  = !is_mul && !in_op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (&in_b);
  end

  // Datapath: one multiply step, one divide step and the final sign fixup.
  always_comb begin
    mul_sum = acc_q;
    for (int unsigned i = 0; i < MUL_UNROLL; i++) begin
      if (b_q[i]) mul_sum = mul_sum + (mcand_q << i);
    end

    // acc holds {remainder, dividend bits not yet consumed}.
    diff     = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    div_next = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    unique case (op_q)
      3'b000:                 fix_result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo;
      default:                fix_result = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = in_op;
          tag_d   = in_tag;
          sa_d    = neg_a;
          sb_d    = neg_b;
          mcand_d = {{XLEN{1'b0}}, a_mag};
          b_d     = b_mag;
          acc_d   = is_mul ? '0 : {{XLEN{1'b0}}, a_mag};
          cnt_d   = is_mul ? MulLast : DivLast;
          dz_d    = div_zero;
          ovf_d   = div_ovf;
          if (div_zero) begin
            result_d = in_op[1] ? in_a : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = in_op[1] ? '0 : in_a;
            state_d  = StDone;
          end else begin
            state_d = is_mul ? StMul : StDiv;
          end
        end
      end
      StMul: begin
        acc_d   = mul_sum;
        mcand_d = mcand_q << MUL_UNROLL;
        b_d     = b_q >> MUL_UNROLL;
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFixup;
      end
      StDiv: begin
        acc_d = div_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) state_d = StFixup;
      end
      StFixup: begin
        result_d = fix_result;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      tag_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: two instances (MUL_UNROLL 1 and 4) on shared stimulus,
// expected results queued at issue and compared when the result appears.
module tb_muldiv_iter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        dz;
    logic        ovf;
    int          lat;
    int          lat4;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a, in_b;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready, out_valid, out_dz, out_ovf;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             in_ready4, out_valid4, out_dz4, out_ovf4;
  logic [XLEN-1:0]  out_result4;
  logic [TAG_W-1:0] out_tag4;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(XLEN), .MUL_UNROLL(1), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_div_by_zero(out_dz), .out_overflow(out_ovf)
  );

  muldiv_iter #(.XLEN(XLEN), .MUL_UNROLL(4), .TAG_W(TAG_W)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid4),
    .out_ready(out_ready), .out_result(out_result4), .out_tag(out_tag4),
    .out_div_by_zero(out_dz4), .out_overflow(out_ovf4)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic with RISC-V corner cases.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64;
    logic [63:0]        p;
    logic signed [31:0] q;
    logic               ovf;
    logic [31:0]        r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'd0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    r    = '0;
    case (op)
      3'd0: begin p = sa64 * sb64; r = p[31:0]; end
      3'd1: begin p = sa64 * sb64; r = p[63:32]; end
      3'd2: begin p = sa64 * ub64; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == '0) r = '1;
        else if (ovf) r = a;
        else begin q = $signed(a) / $signed(b); r = q; end
      end
      3'd5: r = (b == '0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == '0) r = a;
        else if (ovf) r = '0;
        else begin q = $signed(a) % $signed(b); r = q; end
      end
      default: r = (b == '0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] res);
    exp_t e;
    logic fast;
    chk("in_ready_before_issue", 64'(in_ready), 64'd1);
    chk("in_ready4_before_issue", 64'(in_ready4), 64'd1);
    e.res  = res;
    e.tag  = tag;
    e.dz   = op[2] && (b == '0);
    e.ovf  = op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    fast   = e.dz || e.ovf;
    e.lat  = fast ? 1 : int'(XLEN) + 2;
    e.lat4 = fast ? 1 : (op[2] ? int'(XLEN) + 2 : int'(XLEN) / 4 + 2);
    sb.push_back(e);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called one cycle after the accept edge; lat counts cycles since accept.
  task automatic wait_out(output int lat, output int lat4);
    lat  = 1;
    lat4 = 0;
    forever begin
      if (out_valid4 && lat4 == 0) lat4 = lat;
      if (out_valid || lat >= 200) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_out(input int lat, input int lat4);
    exp_t e;
    e = sb.pop_front();
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("result", 64'(out_result), 64'(e.res));
    chk("tag", 64'(out_tag), 64'(e.tag));
    chk("div_by_zero", 64'(out_dz), 64'(e.dz));
    chk("overflow", 64'(out_ovf), 64'(e.ovf));
    chk("latency", 64'(lat), 64'(e.lat));
    chk("latency_unroll4", 64'(lat4), 64'(e.lat4));
    chk("result_unroll4", 64'(out_result4), 64'(e.res));
    chk("tag_unroll4", 64'(out_tag4), 64'(e.tag));
    chk("flags_unroll4", 64'({out_dz4, out_ovf4}), 64'({e.dz, e.ovf}));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
    chk("out_valid_after_handshake", 64'(out_valid), 64'd0);
    chk("in_ready4_after_handshake", 64'(in_ready4), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] res);
    int lat, lat4;
    send(op, a, b, tag, res);
    wait_out(lat, lat4);
    check_out(lat, lat4);
    handshake();
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat, lat4;
    logic        seen;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(out_result), 64'd0);
    chk("reset_tag", 64'(out_tag), 64'd0);
    chk("reset_flags", 64'({out_dz, out_ovf}), 64'd0);

    // Multiply family
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 5'h01, 32'h0000_0000);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'h02, 32'h4000_0000);
    run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 5'h03, 32'h4000_0000);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h04, 32'hFFFF_FFFF);
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 5'h05, 32'hFFFF_FFF1);
    run_op(3'b001, 32'hFFFF_FFFD, 32'h0000_0005, 5'h06, 32'hFFFF_FFFF);

    // Divide family, -7 by 2
    run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'h07, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'h08, 32'hFFFF_FFFF);
    run_op(3'b101, 32'hFFFF_FFF9, 32'h0000_0002, 5'h09, 32'h7FFF_FFFC);
    run_op(3'b111, 32'hFFFF_FFF9, 32'h0000_0002, 5'h0A, 32'h0000_0001);

    // Fast path: divide by zero and signed overflow
    run_op(3'b101, 32'h1234_5678, 32'h0000_0000, 5'h0B, 32'hFFFF_FFFF);
    run_op(3'b111, 32'h1234_5678, 32'h0000_0000, 5'h0C, 32'h1234_5678);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0D, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0E, 32'h0000_0000);

    // Flush 10 cycles into a divide, with a competing request in the same cycle
    send(3'b100, 32'd1000, 32'd7, 5'h10, 32'd142);
    sb.delete(sb.size() - 1);
    repeat (9) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'b000; in_a = 32'd9; in_b = 32'd9;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || out_valid4) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run_op(3'b000, 32'd3, 32'd5, 5'h11, 32'd15);

    // Flush a finished result while the consumer is also ready
    send(3'b000, 32'd7, 32'd6, 5'h12, 32'd42);
    wait_out(lat, lat4);
    sb.delete(sb.size() - 1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_out_valid", 64'(out_valid), 64'd0);
    chk("flush_done_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply
    send(3'b001, 32'h1357_9BDF, 32'hFEDC_BA98, 5'h0F, 32'h0);
    sb.delete(sb.size() - 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_result", 64'(out_result), 64'd0);
    chk("midreset_tag", 64'(out_tag), 64'd0);
    chk("midreset_flags", 64'({out_dz, out_ovf}), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    chk("midreset_in_ready4", 64'(in_ready4), 64'd1);

    // Back-pressure: result held for 5 cycles, handshake in the 6th
    send(3'b101, 32'hCAFE_F00D, 32'h0, 5'h1A, 32'hFFFF_FFFF);
    wait_out(lat, lat4);
    check_out(lat, lat4);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(out_result), 64'hFFFF_FFFF);
      chk("bp_tag", 64'(out_tag), 64'h1A);
      chk("bp_flags", 64'({out_dz, out_ovf}), 64'b10);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    handshake();

    // Mixed operations against the arithmetic model
    for (int k = 0; k < 12; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(op, a, b, 5'(k + 16), model(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
